// File: rtl/deserializer_pkg.sv
// deserializer_pkg
//   Shared types and constants for the serial-to-parallel front stage.
//   - deser_state_t       : FILL (collecting bits) / HOLD (word awaiting ack)
//   - DESER_WIDTH_DEFAULT : default number of bits per assembled word
//   - WORD_COUNT_W        : width of the acknowledged-word counter
package deserializer_pkg;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} deser_state_t;

  localparam int DESER_WIDTH_DEFAULT = 8;
  localparam int WORD_COUNT_W        = 8;

endpackage

// File: rtl/deserializer.sv
// deserializer
//   Assembles WIDTH serial bits (MSB first) into a word and offers it to the
//   downstream queue with a ready/ack handshake.
//
// Ports
//   clock_1MHz  in   system clock, all logic on the rising edge
//   rst         in   synchronous active-high reset
//   data_in     in   serial bit, taken when write_in=1 and status_out=1
//   write_in    in   bit strobe, one bit per high cycle
//   ack_in      in   downstream consumed the word (only looked at in HOLD)
//   status_out  out  1 while accepting serial bits (FILL)
//   data_out    out  last completed word, stable until the next one completes
//   data_ready  out  1 while data_out holds an unacknowledged word (HOLD)
//   word_count  out  acknowledged words, modulo 256
module deserializer
  import deserializer_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
  input  logic                    clock_1MHz,
  input  logic                    rst,
  input  logic                    data_in,
  input  logic                    write_in,
  input  logic                    ack_in,
  output logic                    status_out,
  output logic [WIDTH-1:0]        data_out,
  output logic                    data_ready,
  output logic [WORD_COUNT_W-1:0] word_count
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  deser_state_t     state;
  logic [CNT_W-1:0] bit_cnt;

  // The top bit of a WIDTH-bit shift register would be pushed out before it
  // is ever read (the completing bit is merged straight into data_out), so
  // only the low WIDTH-1 bits are kept.
  logic [WIDTH-2:0] shift;

  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      state      <= FILL;
      shift      <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      word_count <= '0;
    end else if (state == FILL) begin
      // ack_in has no effect here
      if (write_in) begin
        shift <= {shift[WIDTH-3:0], data_in};
        if (bit_cnt == LAST_BIT) begin
          data_out <= {shift, data_in};
          bit_cnt  <= '0;
          state    <= HOLD;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end else begin
      // HOLD: strobes are dropped; the first sampled ack releases the word
      if (ack_in) begin
        state      <= FILL;
        word_count <= word_count + 1'b1;
      end
    end
  end

  // Decoded from the state register only: no input-to-output path.
  assign status_out = (state == FILL);
  assign data_ready = (state == HOLD);

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer
//   Directed bench for deserializer (WIDTH=8): a table of single-cycle vectors
//   with hand-computed expectations, followed by hand-written sequences for
//   gapped strobes, resets mid-operation and back-to-back throughput/wrap.
module tb_deserializer;

  logic       clk = 1'b0;
  logic       rst, data_in, write_in, ack_in;
  logic       status_out, data_ready;
  logic [7:0] data_out, word_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  deserializer #(.WIDTH(8)) dut (
    .clock_1MHz(clk),
    .rst       (rst),
    .data_in   (data_in),
    .write_in  (write_in),
    .ack_in    (ack_in),
    .status_out(status_out),
    .data_out  (data_out),
    .data_ready(data_ready),
    .word_count(word_count)
  );

  typedef struct {
    logic       rst;
    logic       wr;
    logic       din;
    logic       ack;
    logic       exp_status;
    logic       exp_ready;
    logic [7:0] exp_data;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic s, input logic r,
                           input logic [7:0] d, input logic [7:0] c);
    check({tag, ".status_out"}, {31'd0, status_out}, {31'd0, s});
    check({tag, ".data_ready"}, {31'd0, data_ready}, {31'd0, r});
    check({tag, ".data_out"},   {24'd0, data_out},   {24'd0, d});
    check({tag, ".word_count"}, {24'd0, word_count}, {24'd0, c});
  endtask

  task automatic drive(input logic r, input logic w, input logic d, input logic a);
    rst = r; write_in = w; data_in = d; ack_in = a;
  endtask

  task automatic add(input logic r, input logic w, input logic d, input logic a,
                     input logic s, input logic rd, input logic [7:0] dat,
                     input logic [7:0] cnt);
    vec_t v;
    v.rst = r; v.wr = w; v.din = d; v.ack = a;
    v.exp_status = s; v.exp_ready = rd; v.exp_data = dat; v.exp_count = cnt;
    vecs.push_back(v);
  endtask

  // Eight strobes MSB first; data_out keeps prev until the eighth bit lands.
  task automatic add_word(input logic [7:0] w, input logic [7:0] prev, input logic [7:0] cnt);
    for (int b = 0; b < 7; b++) add(0, 1, w[7-b], 0, 1, 0, prev, cnt);
    add(0, 1, w[0], 0, 0, 1, w, cnt);
  endtask

  // Send a full word with one strobe per cycle, no ack.
  task automatic send_word(input logic [7:0] w);
    for (int b = 0; b < 8; b++) begin
      drive(0, 1, w[7-b], 0);
      tick();
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    int   last_rise;
    int   cyc;
    logic [7:0] wv;

    drive(1, 0, 0, 0);

    // ---------------- table ----------------
    add(1, 0, 0, 0, 1, 0, 8'h00, 8'd0);            // reset, cycle 1
    add(1, 0, 0, 0, 1, 0, 8'h00, 8'd0);            // reset, cycle 2
    add_word(8'hB2, 8'h00, 8'd0);                  // 1,0,1,1,0,0,1,0
    add(0, 0, 0, 1, 1, 0, 8'hB2, 8'd1);            // ack
    add_word(8'h3C, 8'hB2, 8'd1);                  // first strobe right after ack
    for (int i = 0; i < 5; i++)
      add(0, 1, 1, 0, 0, 1, 8'h3C, 8'd1);          // strobes in HOLD dropped
    add(0, 0, 0, 1, 1, 0, 8'h3C, 8'd2);            // ack
    add_word(8'h0F, 8'h3C, 8'd2);                  // bit counter was left at 0
    add(0, 0, 0, 1, 1, 0, 8'h0F, 8'd3);            // ack
    add(0, 0, 0, 1, 1, 0, 8'h0F, 8'd3);            // ack in FILL ignored
    add_word(8'h81, 8'h0F, 8'd3);
    add(0, 0, 0, 1, 1, 0, 8'h81, 8'd4);            // ack held two cycles
    add(0, 0, 0, 1, 1, 0, 8'h81, 8'd4);            // ...counts once

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].din, vecs[i].ack);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_status, vecs[i].exp_ready,
                vecs[i].exp_data, vecs[i].exp_count);
    end
    drive(0, 0, 0, 0);

    // ---------------- gapped strobes, acks in FILL ----------------
    wv = 8'hA5;
    for (int b = 0; b < 8; b++) begin
      drive(0, 1, wv[7-b], 0);
      tick();
      if (b < 7) begin
        check_all($sformatf("gap_bit%0d", b), 1, 0, 8'h81, 8'd4);
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 0, 1); tick();   // ack while filling
        drive(0, 0, 1, 0); tick();
        check_all($sformatf("gap_idle%0d", b), 1, 0, 8'h81, 8'd4);
      end
    end
    check_all("gap_done", 0, 1, 8'hA5, 8'd4);
    drive(0, 0, 0, 1); tick();
    check_all("gap_ack", 1, 0, 8'hA5, 8'd5);

    // ---------------- reset after 4 bits ----------------
    for (int b = 0; b < 4; b++) begin
      drive(0, 1, 1, 0); tick();
    end
    drive(1, 1, 1, 1); tick();
    check_all("rst_mid", 1, 0, 8'h00, 8'd0);
    send_word(8'h5A);
    check_all("rst_mid_word", 0, 1, 8'h5A, 8'd0);
    drive(0, 0, 0, 1); tick();
    check_all("rst_mid_ack", 1, 0, 8'h5A, 8'd1);

    // ---------------- reset in HOLD ----------------
    send_word(8'h77);
    check_all("hold_word", 0, 1, 8'h77, 8'd1);
    drive(1, 0, 0, 1); tick();
    check_all("rst_hold", 1, 0, 8'h00, 8'd0);

    // ---------------- 256 words, ack tied high ----------------
    last_rise = 0;
    cyc = 0;
    for (int w = 0; w < 256; w++) begin
      wv = w[7:0];
      for (int b = 0; b < 8; b++) begin
        drive(0, 1, wv[7-b], 1);
        tick();
        cyc++;
      end
      check($sformatf("tp_ready%0d", w), {31'd0, data_ready}, 32'd1);
      check($sformatf("tp_data%0d", w), {24'd0, data_out}, {24'd0, wv});
      if (w > 0) check($sformatf("tp_period%0d", w), cyc - last_rise, 32'd9);
      last_rise = cyc;
      // HOLD cycle: strobe with inverted data must be dropped
      drive(0, 1, ~wv[7], 1);
      tick();
      cyc++;
      check($sformatf("tp_count%0d", w), {24'd0, word_count}, (w + 1) % 256);
      check($sformatf("tp_fill%0d", w), {31'd0, status_out}, 32'd1);
    end
    drive(0, 0, 0, 0);
    check("tp_wrap_count", {24'd0, word_count}, 32'd0);
    check("tp_last_data", {24'd0, data_out}, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
